// File: rtl/write_back_buffer.sv
// Posted write buffer between the cache write-back port and main memory, with read-miss forwarding.
// Optional build macro WBB_COALESCE_EN merges a write into an already-buffered, non-head entry of the same address.
module write_back_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    memory_write_enable,
   input  logic [ADDR_WIDTH-1:0]   memory_write_address,
   input  logic [DATA_WIDTH-1:0]   memory_write_data,
   output logic                    memory_write_complete,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_data,
   input  logic                    mem_ack,
   input  logic [ADDR_WIDTH-1:0]   lookup_address,
   output logic                    lookup_hit,
   output logic [DATA_WIDTH-1:0]   lookup_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] addrQ [DEPTH];
   logic [DATA_WIDTH-1:0] dataQ [DEPTH];

   logic [PTR_W-1:0] wrPtrQ, wrPtrD;
   logic [PTR_W-1:0] rdPtrQ, rdPtrD;
   logic [CNT_W-1:0] countQ, countD;
   logic             completeQ, completeD;

   logic isFull, isEmpty;
   logic accept, doAlloc, doPop, doCoalesce, coalHit;

   assign isFull  = (countQ == CNT_W'(DEPTH));
   assign isEmpty = (countQ == '0);

`ifdef WBB_COALESCE_EN
   logic [PTR_W-1:0] coalIdx;
   logic [PTR_W-1:0] coalProbe;

   // Newest non-head buffered entry with the incoming address; the head may be mid-transfer so it is never merged into.
   always_comb begin
      coalHit   = 1'b0;
      coalIdx   = rdPtrQ;
      coalProbe = rdPtrQ;
      for (int i = 1; i < DEPTH; i++) begin
         coalProbe = rdPtrQ + PTR_W'(i);
         if ((CNT_W'(i) < countQ) && (addrQ[coalProbe] == memory_write_address)) begin
            coalHit = 1'b1;
            coalIdx = coalProbe;
         end
      end
   end
`else
   assign coalHit = 1'b0;
`endif

   always_comb begin
      accept     = memory_write_enable && !completeQ && (!isFull || coalHit);
      doCoalesce = accept && coalHit;
      doAlloc    = accept && !coalHit;
      doPop      = !isEmpty && mem_ack;

      completeD = accept;
      wrPtrD    = doAlloc ? wrPtrQ + PTR_W'(1) : wrPtrQ;
      rdPtrD    = doPop ? rdPtrQ + PTR_W'(1) : rdPtrQ;
      countD    = countQ;
      if (doAlloc && !doPop) begin
         countD = countQ + CNT_W'(1);
      end else if (!doAlloc && doPop) begin
         countD = countQ - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtrQ    <= '0;
         rdPtrQ    <= '0;
         countQ    <= '0;
         completeQ <= 1'b0;
      end else begin
         wrPtrQ    <= wrPtrD;
         rdPtrQ    <= rdPtrD;
         countQ    <= countD;
         completeQ <= completeD;
      end
   end

   // Entry storage needs no reset: validity is derived from the occupancy window starting at rdPtrQ.
   always_ff @(posedge clk) begin
      if (doAlloc) begin
         addrQ[wrPtrQ] <= memory_write_address;
         dataQ[wrPtrQ] <= memory_write_data;
      end
`ifdef WBB_COALESCE_EN
      if (doCoalesce) begin
         dataQ[coalIdx] <= memory_write_data;
      end
`endif
   end

   logic [PTR_W-1:0] lookIdx;

   // Walk from oldest to newest so the last match, the youngest copy, is the one forwarded.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      lookIdx     = rdPtrQ;
      for (int i = 0; i < DEPTH; i++) begin
         lookIdx = rdPtrQ + PTR_W'(i);
         if ((CNT_W'(i) < countQ) && (addrQ[lookIdx] == lookup_address)) begin
            lookup_hit  = 1'b1;
            lookup_data = dataQ[lookIdx];
         end
      end
   end

   assign memory_write_complete = completeQ;
   assign mem_req               = !isEmpty;
   assign mem_addr              = isEmpty ? '0 : addrQ[rdPtrQ];
   assign mem_data              = isEmpty ? '0 : dataQ[rdPtrQ];
   assign full                  = isFull;
   assign empty                 = isEmpty;
   assign count                 = countQ;

endmodule

// File: tb/tb_write_back_buffer.sv
// Testbench for write_back_buffer: directed vector table, hand-written corner sequences and a randomized
// run against a queue-based reference model (model honours WBB_COALESCE_EN when defined).
module tb_write_back_buffer;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          memory_write_enable;
   logic [AW-1:0] memory_write_address;
   logic [DW-1:0] memory_write_data;
   logic          memory_write_complete;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_ack;
   logic [AW-1:0] lookup_address;
   logic          lookup_hit;
   logic [DW-1:0] lookup_data;
   logic          full;
   logic          empty;
   logic [2:0]    count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   write_back_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .memory_write_enable   (memory_write_enable),
      .memory_write_address  (memory_write_address),
      .memory_write_data     (memory_write_data),
      .memory_write_complete (memory_write_complete),
      .mem_req               (mem_req),
      .mem_addr              (mem_addr),
      .mem_data              (mem_data),
      .mem_ack               (mem_ack),
      .lookup_address        (lookup_address),
      .lookup_hit            (lookup_hit),
      .lookup_data           (lookup_data),
      .full                  (full),
      .empty                 (empty),
      .count                 (count)
   );

   typedef struct {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          ack;
      logic [AW-1:0] look;
      logic          expComplete;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expData;
      int            expCount;
      logic          expHit;
      logic [DW-1:0] expLook;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } entry_t;

   vec_t   vecs[$];
   entry_t mq[$];
   bit     mComplete;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, let the rising edge happen, then settle before sampling.
   task automatic applyStimulus(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic ack, input logic [AW-1:0] look);
      memory_write_enable  = en;
      memory_write_address = a;
      memory_write_data    = d;
      mem_ack              = ack;
      lookup_address       = look;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVector(input string tag, input logic c, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                              input int cnt, input logic h, input logic [DW-1:0] ld);
      checkOutput({tag, ".complete"}, 64'(memory_write_complete), 64'(c));
      checkOutput({tag, ".mem_req"},  64'(mem_req),  64'(cnt != 0));
      checkOutput({tag, ".mem_addr"}, 64'(mem_addr), 64'(ea));
      checkOutput({tag, ".mem_data"}, 64'(mem_data), 64'(ed));
      checkOutput({tag, ".count"},    64'(count),    64'(cnt));
      checkOutput({tag, ".full"},     64'(full),     64'(cnt == DEPTH));
      checkOutput({tag, ".empty"},    64'(empty),    64'(cnt == 0));
      checkOutput({tag, ".hit"},      64'(lookup_hit),  64'(h));
      checkOutput({tag, ".lookdata"}, 64'(lookup_data), 64'(ld));
   endtask

   function automatic void addVec(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack,
                                  input logic [AW-1:0] look, input logic c, input logic [AW-1:0] ea,
                                  input logic [DW-1:0] ed, input int cnt, input logic h, input logic [DW-1:0] ld);
      vec_t v;
      v.en = en; v.addr = a; v.data = d; v.ack = ack; v.look = look;
      v.expComplete = c; v.expAddr = ea; v.expData = ed; v.expCount = cnt; v.expHit = h; v.expLook = ld;
      vecs.push_back(v);
   endfunction

   // Reference model: a FIFO queue of pending writes, updated once per clock edge.
   function automatic void modelStep(input bit rst, input logic en, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic ack);
      int  n;
      int  coalIdx;
      bit  pop;
      bit  acc;
      if (rst) begin
         mq.delete();
         mComplete = 0;
         return;
      end
      n       = mq.size();
      coalIdx = -1;
      pop     = (n > 0) && ack;
`ifdef WBB_COALESCE_EN
      for (int i = 1; i < n; i++) begin
         if (mq[i].a == a) coalIdx = i;
      end
`endif
      acc = en && !mComplete && ((coalIdx >= 0) || (n < DEPTH));
      if (acc && coalIdx >= 0) mq[coalIdx].d = d;
      if (pop) void'(mq.pop_front());
      if (acc && coalIdx < 0) mq.push_back('{a: a, d: d});
      mComplete = acc;
   endfunction

   task automatic checkModel(input logic [AW-1:0] look);
      logic          h;
      logic [DW-1:0] ld;
      int            n;
      n  = mq.size();
      h  = 1'b0;
      ld = '0;
      for (int i = 0; i < n; i++) begin
         if (mq[i].a == look) begin
            h  = 1'b1;
            ld = mq[i].d;
         end
      end
      checkVector("rand", mComplete, (n > 0) ? mq[0].a : '0, (n > 0) ? mq[0].d : '0, n, h, ld);
   endtask

   initial begin
      bit            pending;
      bit            rst;
      logic [AW-1:0] pAddr;
      logic [DW-1:0] pData;
      logic          ack;
      logic [AW-1:0] look;
      int            coalCnt;

      reset = 1'b1;
      applyStimulus(0, '0, '0, 0, '0);
      applyStimulus(0, '0, '0, 1, '0);
      checkVector("reset", 0, '0, '0, 0, 0, '0);
      reset = 1'b0;

      // Single write held for several cycles, then drained.
      addVec(1, 32'h1000, 32'hDEADBEEF, 0, 32'h1000, 1, 32'h1000, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
      for (int i = 0; i < 5; i++)
         addVec(0, '0, '0, 0, 32'h1000, 0, 32'h1000, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF);
      addVec(0, '0, '0, 1, 32'h1000, 0, '0, '0, 0, 0, '0);
      // Fill to full, block the fifth write across a pop, then drain in order.
      addVec(1, 32'h40,  32'h11111111, 0, 32'h80, 1, 32'h40, 32'h11111111, 1, 0, '0);
      addVec(1, 32'h80,  32'h22222222, 0, 32'h80, 0, 32'h40, 32'h11111111, 1, 0, '0);
      addVec(1, 32'h80,  32'h22222222, 0, 32'h80, 1, 32'h40, 32'h11111111, 2, 1, 32'h22222222);
      addVec(1, 32'hC0,  32'h33333333, 0, 32'h80, 0, 32'h40, 32'h11111111, 2, 1, 32'h22222222);
      addVec(1, 32'hC0,  32'h33333333, 0, 32'h80, 1, 32'h40, 32'h11111111, 3, 1, 32'h22222222);
      addVec(1, 32'h100, 32'h44444444, 0, 32'h80, 0, 32'h40, 32'h11111111, 3, 1, 32'h22222222);
      addVec(1, 32'h100, 32'h44444444, 0, 32'h80, 1, 32'h40, 32'h11111111, 4, 1, 32'h22222222);
      addVec(1, 32'h140, 32'h55555555, 0, 32'h80, 0, 32'h40, 32'h11111111, 4, 1, 32'h22222222);
      addVec(1, 32'h140, 32'h55555555, 0, 32'h80, 0, 32'h40, 32'h11111111, 4, 1, 32'h22222222);
      addVec(1, 32'h140, 32'h55555555, 1, 32'h80, 0, 32'h80, 32'h22222222, 3, 1, 32'h22222222);
      addVec(1, 32'h140, 32'h55555555, 0, 32'h80, 1, 32'h80, 32'h22222222, 4, 1, 32'h22222222);
      addVec(0, '0, '0, 1, 32'h80, 0, 32'hC0,  32'h33333333, 3, 0, '0);
      addVec(0, '0, '0, 1, 32'h80, 0, 32'h100, 32'h44444444, 2, 0, '0);
      addVec(0, '0, '0, 1, 32'h80, 0, 32'h140, 32'h55555555, 1, 0, '0);
      addVec(0, '0, '0, 1, 32'h80, 0, '0, '0, 0, 0, '0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].look);
         checkVector($sformatf("vec%0d", i), vecs[i].expComplete, vecs[i].expAddr, vecs[i].expData,
                     vecs[i].expCount, vecs[i].expHit, vecs[i].expLook);
      end

      // Duplicate address behind the head: the youngest copy is forwarded until both drain.
      applyStimulus(1, 32'h80, 32'hAAAA0000, 0, 32'h80);
      checkVector("lk0", 1, 32'h80, 32'hAAAA0000, 1, 1, 32'hAAAA0000);
      applyStimulus(1, 32'h80, 32'hBBBB0000, 0, 32'h80);
      checkVector("lk1", 0, 32'h80, 32'hAAAA0000, 1, 1, 32'hAAAA0000);
      applyStimulus(1, 32'h80, 32'hBBBB0000, 0, 32'h80);
      checkVector("lk2", 1, 32'h80, 32'hAAAA0000, 2, 1, 32'hBBBB0000);
      applyStimulus(0, '0, '0, 1, 32'h80);
      checkVector("lk3", 0, 32'h80, 32'hBBBB0000, 1, 1, 32'hBBBB0000);
      applyStimulus(0, '0, '0, 1, 32'h80);
      checkVector("lk4", 0, '0, '0, 0, 0, '0);

      // Same address twice behind a different head: merged only with coalescing built in.
`ifdef WBB_COALESCE_EN
      coalCnt = 2;
`else
      coalCnt = 3;
`endif
      applyStimulus(1, 32'h40, 32'h1, 0, 32'h80);
      applyStimulus(0, '0, '0, 0, 32'h80);
      applyStimulus(1, 32'h80, 32'h2, 0, 32'h80);
      applyStimulus(0, '0, '0, 0, 32'h80);
      applyStimulus(1, 32'h80, 32'h3, 0, 32'h80);
      checkVector("co0", 1, 32'h40, 32'h1, coalCnt, 1, 32'h3);
      applyStimulus(0, '0, '0, 1, 32'h80);
      checkVector("co1", 0, 32'h80, (coalCnt == 2) ? 32'h3 : 32'h2, coalCnt - 1, 1, 32'h3);
      applyStimulus(0, '0, '0, 1, 32'h80);
      if (coalCnt == 3) begin
         checkVector("co2", 0, 32'h80, 32'h3, 1, 1, 32'h3);
         applyStimulus(0, '0, '0, 1, 32'h80);
      end
      checkVector("co3", 0, '0, '0, 0, 0, '0);

      // A write matching only the head entry always allocates a new slot.
      applyStimulus(1, 32'h40, 32'h1, 0, 32'h40);
      applyStimulus(0, '0, '0, 0, 32'h40);
      applyStimulus(1, 32'h40, 32'h9, 0, 32'h40);
      checkVector("hd0", 1, 32'h40, 32'h1, 2, 1, 32'h9);
      applyStimulus(0, '0, '0, 1, 32'h40);
      applyStimulus(0, '0, '0, 1, 32'h40);
      checkVector("hd1", 0, '0, '0, 0, 0, '0);

      // Push and pop on the same edge at count 2.
      applyStimulus(1, 32'h200, 32'hA1, 0, 32'h204);
      applyStimulus(0, '0, '0, 0, 32'h204);
      applyStimulus(1, 32'h204, 32'hB1, 0, 32'h204);
      applyStimulus(0, '0, '0, 0, 32'h204);
      checkVector("pp0", 0, 32'h200, 32'hA1, 2, 1, 32'hB1);
      applyStimulus(1, 32'h208, 32'hC1, 1, 32'h204);
      checkVector("pp1", 1, 32'h204, 32'hB1, 2, 1, 32'hB1);
      applyStimulus(0, '0, '0, 1, 32'h204);
      checkVector("pp2", 0, 32'h208, 32'hC1, 1, 0, '0);

      // Reset while draining discards everything at once.
      applyStimulus(1, 32'h300, 32'h7, 0, 32'h208);
      applyStimulus(0, '0, '0, 0, 32'h208);
      applyStimulus(1, 32'h304, 32'h8, 0, 32'h208);
      checkVector("rs0", 1, 32'h208, 32'hC1, 3, 1, 32'hC1);
      reset = 1'b1;
      applyStimulus(0, '0, '0, 0, 32'h208);
      reset = 1'b0;
      checkVector("rs1", 0, '0, '0, 0, 0, '0);

      // Randomized run against the queue model; the cache side holds enable until it sees complete.
      modelStep(1, 0, '0, '0, 0);
      pending = 0;
      pAddr   = '0;
      pData   = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (mComplete) pending = 0;
         if (!pending && $urandom_range(0, 2) != 0) begin
            pending = 1;
            pAddr   = 32'h1000 + 32'($urandom_range(0, 5) << 2);
            pData   = $urandom;
         end
         ack  = ($urandom_range(0, 3) == 0);
         look = 32'h1000 + 32'($urandom_range(0, 5) << 2);
         rst  = ($urandom_range(0, 99) == 0);
         reset = rst;
         applyStimulus(pending, pAddr, pData, ack, look);
         reset = 1'b0;
         modelStep(rst, pending, pAddr, pData, ack);
         if (rst) pending = 0;
         checkModel(look);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
